// File: rtl/cpu_pkg.sv
// Shared definitions for the lab CPU front end: sequencer state encoding,
// opcode constants and default bus widths.
package cpu_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 8;

  // Major opcode field instr[7:6]; only the jump opcode is decoded here.
  localparam logic [1:0] OP_JMP = 2'b11;

  // Encoding is visible on the board LEDs, so values are fixed.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC adder: pc + 1, plus a sign-extended 6-bit offset for jumps.
// Arithmetic wraps modulo 2^ADDR_W. Kept separate so a later branch unit
// can reuse it.
module pc_next
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic [ADDR_W-1:0]  o_next_pc
);

  logic              w_is_jmp;
  logic [ADDR_W-1:0] w_offset;

  assign w_is_jmp  = (i_instr[7:6] == OP_JMP);
  assign w_offset  = {{(ADDR_W-6){i_instr[5]}}, i_instr[5:0]};
  assign o_next_pc = i_pc + ADDR_W'(1) + (w_is_jmp ? w_offset : '0);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue controller for the lab CPU instruction ROM.
// IDLE -> FETCH -> ISSUE -> (FETCH | IDLE | HALT). The ROM is combinational,
// so rom_addr follows pc directly and the word is latched in FETCH.
// Optional build macro SEQ_RETIRE_CNT_EN adds a saturating 16-bit count of
// accepted instructions on output retired_cnt.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int PROG_LEN = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               ex_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [1:0]         state
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]        retired_cnt
`endif
);

  // Unsigned compare against the wrapped next_pc.
  localparam logic [ADDR_W-1:0] LP_PROG_END = ADDR_W'(PROG_LEN);

  seq_state_e         r_state;
  seq_state_e         w_state_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_next_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               w_accept;
  logic               w_instr_load;

  pc_next #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_pc_next (
    .i_pc      (r_pc),
    .i_instr   (r_instr),
    .o_next_pc (w_next_pc)
  );

  // State register; reset aborts any pending issue at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and control strobes; step is only looked at in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_instr_load = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run || step) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        w_instr_load = 1'b1;
        w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (ex_ready) begin
          w_accept = 1'b1;
          if (w_next_pc >= LP_PROG_END) w_state_next = S_HALT;
          else if (run)                 w_state_next = S_FETCH;
          else                          w_state_next = S_IDLE;
        end
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Program counter advances only when the datapath accepts the instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_pc <= '0;
    else if (w_accept) r_pc <= w_next_pc;
  end

  // Instruction register, loaded from the ROM at the end of FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_instr <= '0;
    else if (w_instr_load) r_instr <= rom_data;
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] r_retired_cnt;

  // Saturating count of accepted instructions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   r_retired_cnt <= '0;
    else if (w_accept && r_retired_cnt != 16'hFFFF) r_retired_cnt <= r_retired_cnt + 16'd1;
  end

  assign retired_cnt = r_retired_cnt;
`endif

  assign rom_addr    = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = (r_state == S_ISSUE);
  assign halted      = (r_state == S_HALT);
  assign state       = r_state;

endmodule
